button_debounce: RTL and testbench
==================================

# button_debounce

Input conditioner for the board push-button, sitting between the raw button pin and the LED/control logic that consumes it. Synchronises the asynchronous pin, rejects contact bounce, and publishes a clean pressed level, single-cycle press/release/long-press events and a wrapping press counter. Downstream blocks use `btn_level` in place of the raw pin.

## Interface
- `DEBOUNCE_CYCLES`, default 270_000 (10 ms at 27 MHz): consecutive stable synchronised samples required to accept a level change; must be ≥ 2.
- `LONG_CYCLES`, default 27_000_000 (1 s at 27 MHz): cycles of accepted press before `btn_long` fires; must be > `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, default 1: 1 means the pin reads 0 when pressed.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `button` in 1: raw, asynchronous, bouncing pin.
- `btn_level` out 1: debounced state, 1 = pressed (polarity normalised).
- `btn_press` out 1: one-cycle pulse on accepted press.
- `btn_release` out 1: one-cycle pulse on accepted release.
- `btn_long` out 1: one-cycle pulse when a press has lasted `LONG_CYCLES`.
- `press_cnt` out 8: count of accepted presses, wraps 255 → 0.

## Operation
- Two-flop synchroniser; both flops reset to the released pin value (1 when `ACTIVE_LOW`). `pressed_s` = synchronised sample normalised to active-high.
- FSM states: `RELEASED`, `PRESS_WAIT`, `PRESSED`, `LONG_HELD`, `RELEASE_WAIT`.
- `RELEASED`: `pressed_s`=1 → `PRESS_WAIT`, debounce counter = 1.
- `PRESS_WAIT`: `pressed_s`=0 → `RELEASED` (glitch rejected, no output change). Otherwise increment; on the `DEBOUNCE_CYCLES`-th consecutive sample → `PRESSED`; same edge: `btn_level`←1, `btn_press` pulse, `press_cnt`+1, hold counter cleared.
- `PRESSED`: hold counter increments each cycle; reaching `LONG_CYCLES` → `LONG_HELD`, `btn_long` pulse, `long_done`←1. `pressed_s`=0 → `RELEASE_WAIT`, debounce counter = 1.
- `LONG_HELD`: `pressed_s`=0 → `RELEASE_WAIT`. No further `btn_long` for this press.
- `RELEASE_WAIT`: hold counter frozen. `pressed_s`=1 → back to `PRESSED` (`long_done`=0) or `LONG_HELD` (`long_done`=1), no pulse. On the `DEBOUNCE_CYCLES`-th consecutive released sample → `RELEASED`; `btn_level`←0, `btn_release` pulse, `long_done`←0.
- Long threshold and debounce threshold in the same cycle cannot collide (distinct states); the hold counter saturates at `LONG_CYCLES`.
- Counter widths: `$clog2(DEBOUNCE_CYCLES+1)` and `$clog2(LONG_CYCLES+1)`; no overflow possible.

## Timing
- Reset (`rst`=0 at an edge): state `RELEASED`, all counters 0, `long_done`=0; `btn_level`=0, `btn_press`=0, `btn_release`=0, `btn_long`=0, `press_cnt`=0. Reset mid-press yields no `btn_release`.
- All outputs registered. Pin change set up before edge k, held clean: `btn_level` and the event pulse become visible after edge k+1+`DEBOUNCE_CYCLES`.
- `btn_long` visible after edge k+1+`DEBOUNCE_CYCLES`+`LONG_CYCLES`, given continuous press.
- Pulses are exactly one cycle wide; at most one of `btn_press`/`btn_release`/`btn_long` high in any cycle.
- `press_cnt` updates on the same edge as `btn_press`.

## Structure
- Shared package `board_pkg`: board clock constant `CLK_HZ` = 27_000_000, FSM state encoding constants (3-bit), default timing constants derived from `CLK_HZ`.
- One sub-module: `sync_2ff` (parameterised reset value), reusable for other board inputs.
- The FSM, counters and output registers live in `button_debounce`.

## Test plan
Sim parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `ACTIVE_LOW`=1.
- Reset: hold `rst`=0 for 3 cycles, `button`=1 → all outputs 0, `press_cnt`=0.
- Clean press: `button` 1→0 before edge 10, held → `btn_level`=1 and `btn_press` one cycle after edge 15; `press_cnt`=1.
- Bounce: pin toggles 0/1 every 2 cycles for 12 cycles, then stays 0 → exactly one `btn_press`; `btn_level` rises 5 edges after last toggle.
- Glitch: 3-cycle low pulse on `button` → no output change, `press_cnt` unchanged.
- Long press: hold pressed 40 cycles → `btn_press`, then `btn_long` exactly 20 cycles later, once; release → one `btn_release`.
- Wrap and reset mid-press: 256 clean presses → `press_cnt`=0; press, assert `rst` while `btn_level`=1 → `btn_level`=0 next edge, no `btn_release`.

Source files
------------

// File: rtl/board_pkg.sv
// board_pkg: board clock, derived default timings and debounce FSM state encoding.
package board_pkg;
  localparam int CLK_HZ = 27_000_000;
  localparam int DEBOUNCE_DEFAULT = CLK_HZ / 100;
  localparam int LONG_DEFAULT = CLK_HZ;
  typedef enum logic [2:0] {
    RELEASED     = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    LONG_HELD    = 3'd3,
    RELEASE_WAIT = 3'd4
  } btn_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous board input, with selectable reset value.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronised, debounced push-button with press/release/long events and press counter.
module button_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES     = LONG_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_long,
  output logic [7:0] press_cnt
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES);
  logic sync_s, pressed_s;
  btn_state_e state_q, state_d;
  logic [DW-1:0] deb_q, deb_d, deb_inc;
  logic [LW-1:0] hold_q, hold_d, hold_inc;
  logic [7:0] cnt_q, cnt_d;
  logic long_done_q, long_done_d, level_q, level_d;
  logic press_q, press_d, release_q, release_d, long_q, long_d;
  sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (button),
    .q   (sync_s)
  );
  assign pressed_s = sync_s ^ ACTIVE_LOW;
  assign deb_inc   = deb_q + DW'(1);
  assign hold_inc  = hold_q + LW'(1);
  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    case (state_q)
      RELEASED: begin
        if (pressed_s) begin
          state_d = PRESS_WAIT;
          deb_d   = DW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = RELEASED;
        end else if (deb_inc == DEB_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          hold_d  = '0;
        end else begin
          deb_d = deb_inc;
        end
      end
      PRESSED: begin
        if (!pressed_s) begin
          state_d = RELEASE_WAIT;
          deb_d   = DW'(1);
        end else if (hold_inc == HOLD_LAST) begin
          state_d     = LONG_HELD;
          hold_d      = hold_inc;
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end else begin
          hold_d = hold_inc;
        end
      end
      LONG_HELD: begin
        if (!pressed_s) begin
          state_d = RELEASE_WAIT;
          deb_d   = DW'(1);
        end
      end
      RELEASE_WAIT: begin
        // a bounce back to pressed resumes the press without a new event
        if (pressed_s) begin
          state_d = long_done_q ? LONG_HELD : PRESSED;
        end else if (deb_inc == DEB_LAST) begin
          state_d     = RELEASED;
          level_d     = 1'b0;
          release_d   = 1'b1;
          long_done_d = 1'b0;
        end else begin
          deb_d = deb_inc;
        end
      end
      default: state_d = RELEASED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RELEASED;
      deb_q       <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end
  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign press_cnt   = cnt_q;
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: random and directed stimulus checked cycle by cycle against a run-length model.
module tb_button_debounce;
  localparam int D = 4;
  localparam int L = 20;
  logic clk = 1'b0, rst = 1'b0, button = 1'b1;
  logic btn_level, btn_press, btn_release, btn_long;
  logic [7:0] press_cnt;
  int checks = 0, errors = 0;
  int cyc = 0, n_press = 0, n_rel = 0, n_long = 0, t_press = 0, t_long = 0;
  logic m_p1, m_p2, m_level, m_done, m_press, m_rel, m_long;
  int m_run, m_hold;
  logic [7:0] m_cnt;

  always #5 clk = ~clk;

  button_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .button      (button),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .press_cnt   (press_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Acceptance = D consecutive synchronised samples differing from the accepted level;
  // hold time = cycles pressed with no pending release since the accepted press.
  task automatic model_edge();
    logic s;
    int run_old;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (!rst) begin
      m_p1 = 1'b1; m_p2 = 1'b1; m_level = 1'b0; m_done = 1'b0;
      m_run = 0; m_hold = 0; m_cnt = 8'd0;
      return;
    end
    s = ~m_p2;
    m_p2 = m_p1;
    m_p1 = button;
    run_old = m_run;
    m_run = (s != m_level) ? m_run + 1 : 0;
    if (m_run == D) begin
      m_level = s;
      m_run = 0;
      m_done = 1'b0;
      if (s) begin
        m_press = 1'b1;
        m_cnt = m_cnt + 8'd1;
        m_hold = 0;
      end else begin
        m_rel = 1'b1;
      end
    end else if (m_level && s && run_old == 0 && !m_done) begin
      m_hold++;
      if (m_hold == L) begin
        m_long = 1'b1;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic b);
    button = b;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("level", btn_level, m_level);
    chk("press", btn_press, m_press);
    chk("release", btn_release, m_rel);
    chk("long", btn_long, m_long);
    chk("cnt", press_cnt, m_cnt);
    if (btn_press) begin n_press++; t_press = cyc; end
    if (btn_release) n_rel++;
    if (btn_long) begin n_long++; t_long = cyc; end
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  initial begin
    int t;
    logic [7:0] saved;
    rst = 1'b0;
    hold(1'b1, 3);
    chk("rst_level", btn_level, 1'b0);
    chk("rst_cnt", press_cnt, 8'd0);
    rst = 1'b1;
    hold(1'b1, 5);

    t = 0;
    do begin tick(1'b0); t++; end while (!btn_level && t < 20);
    chk("press_latency", t, D + 2);
    chk("press_pulse", btn_press, 1'b1);
    chk("press_cnt1", press_cnt, 8'd1);
    hold(1'b0, 3);
    hold(1'b1, 10);

    n_press = 0;
    for (int i = 0; i < 3; i++) begin
      hold(1'b0, 2);
      hold(1'b1, 2);
    end
    t = 0;
    do begin tick(1'b0); t++; end while (!btn_level && t < 20);
    chk("bounce_latency", t, D + 2);
    hold(1'b0, 10);
    chk("bounce_presses", n_press, 1);
    hold(1'b1, 10);

    saved = press_cnt;
    hold(1'b0, 3);
    hold(1'b1, 10);
    chk("glitch_level", btn_level, 1'b0);
    chk("glitch_cnt", press_cnt, saved);

    n_press = 0; n_rel = 0; n_long = 0;
    hold(1'b0, 40);
    hold(1'b1, 10);
    chk("long_presses", n_press, 1);
    chk("long_count", n_long, 1);
    chk("long_delay", t_long - t_press, L);
    chk("long_releases", n_rel, 1);

    for (int i = 0; i < 300; i++)
      hold(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? $urandom_range(25, 45) : $urandom_range(1, 8));
    hold(1'b1, 10);

    rst = 1'b0;
    tick(1'b1);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      hold(1'b0, D + 3);
      hold(1'b1, D + 3);
    end
    chk("wrap_cnt", press_cnt, 8'd0);

    t = 0;
    do begin tick(1'b0); t++; end while (!btn_level && t < 20);
    chk("mid_press_level", btn_level, 1'b1);
    n_rel = 0;
    rst = 1'b0;
    tick(1'b0);
    chk("mid_rst_level", btn_level, 1'b0);
    rst = 1'b1;
    hold(1'b1, 10);
    chk("mid_rst_release", n_rel, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
